pong_game_ctrl: RTL and testbench

- Game-state controller directly downstream of the pong ball/paddle stage.
- Consumes the per-frame update tick, paddle-hit pulses and ball vertical position.
- Produces the ball motion enable and serve (re-launch) pulse, plus BCD score, remaining lives and game-over for the overlay/7-seg logic.
- Runs in the pixel clock domain alongside the ball logic.

---
 rtl/pong_game_ctrl.sv | 137 +++++++++++++
 tb/tb_pong_game_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_game_ctrl.sv
// Pong game-state controller: serve hold-off, BCD scoring, lives and game-over.
// Sits after the ball/paddle stage in the pixel clock domain; all outputs registered.
module pong_game_ctrl #(
  parameter int unsigned LIVES_INIT   = 3,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned MISS_Y       = 450
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       paddle_hit,
  input  logic [8:0] ball_y,
  output logic       ball_move_en,
  output logic       ball_serve,
  output logic [7:0] score_bcd,
  output logic [1:0] lives,
  output logic       game_over,
  output logic [2:0] state_dbg
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] SERVE     = 3'd1;
  localparam logic [2:0] PLAY      = 3'd2;
  localparam logic [2:0] MISS      = 3'd3;
  localparam logic [2:0] GAME_OVER = 3'd4;

  localparam logic [1:0] LIVES_LOAD = 2'(LIVES_INIT);
  localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [8:0] MISS_ROW   = 9'(MISS_Y);

  logic [2:0] state;
  logic [2:0] stateNext;
  logic [7:0] scoreQ;
  logic [1:0] livesQ;
  logic [7:0] frameCnt;
  logic       hitSeen;
  logic       startQ;
  logic       moveEnQ;
  logic       serveQ;
  logic       gameOverQ;

  logic startRise;
  logic missTick;
  logic scoreHit;

  // Saturating two-digit BCD increment.
  function automatic logic [7:0] bcdInc(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h99)
      r = v;
    else if (v[3:0] == 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  assign startRise = start_btn & ~startQ;
  assign missTick  = frame_tick && (ball_y >= MISS_ROW);
  assign scoreHit  = (state == PLAY) && paddle_hit && !hitSeen;

  // Next-state selection for the game FSM.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE, GAME_OVER: if (startRise) stateNext = SERVE;
      SERVE:           if (frame_tick && frameCnt == SERVE_LAST) stateNext = PLAY;
      PLAY:            if (missTick) stateNext = MISS;
      MISS:            stateNext = (livesQ == 2'd1) ? GAME_OVER : SERVE;
      default:         stateNext = IDLE;
    endcase
  end

  // State, counters, score/lives bookkeeping and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      scoreQ    <= '0;
      livesQ    <= LIVES_LOAD;
      frameCnt  <= '0;
      hitSeen   <= 1'b0;
      startQ    <= 1'b1;
      moveEnQ   <= 1'b0;
      serveQ    <= 1'b0;
      gameOverQ <= 1'b0;
    end else begin
      startQ    <= start_btn;
      state     <= stateNext;
      // Move enable and game-over track the state being entered so they
      // stay registered yet line up exactly with state_dbg.
      moveEnQ   <= (stateNext == PLAY);
      gameOverQ <= (stateNext == GAME_OVER);
      serveQ    <= 1'b0;
      case (state)
        IDLE, GAME_OVER: begin
          if (startRise) begin
            scoreQ   <= '0;
            livesQ   <= LIVES_LOAD;
            frameCnt <= '0;
            hitSeen  <= 1'b0;
            serveQ   <= 1'b1;
          end
        end
        SERVE: begin
          hitSeen <= 1'b0;
          if (frame_tick)
            frameCnt <= (frameCnt == SERVE_LAST) ? '0 : frameCnt + 8'd1;
        end
        PLAY: begin
          if (scoreHit)
            scoreQ <= bcdInc(scoreQ);
          // A hit coinciding with frame_tick is scored but the tick still opens a fresh frame.
          hitSeen <= frame_tick ? 1'b0 : (hitSeen | paddle_hit);
        end
        MISS: begin
          if (livesQ == 2'd1) begin
            livesQ <= '0;
          end else begin
            livesQ   <= livesQ - 2'd1;
            frameCnt <= '0;
            serveQ   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ball_move_en = moveEnQ;
  assign ball_serve   = serveQ;
  assign score_bcd    = scoreQ;
  assign lives        = livesQ;
  assign game_over    = gameOverQ;
  assign state_dbg    = state;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed self-checking bench for pong_game_ctrl with default parameters.
module tb_pong_game_ctrl;

  logic       clk;
  logic       rst;
  logic       frame_tick;
  logic       start_btn;
  logic       paddle_hit;
  logic [8:0] ball_y;
  logic       ball_move_en;
  logic       ball_serve;
  logic [7:0] score_bcd;
  logic [1:0] lives;
  logic       game_over;
  logic [2:0] state_dbg;

  int checks = 0;
  int errors = 0;

  pong_game_ctrl #(
    .LIVES_INIT  (3),
    .SERVE_FRAMES(60),
    .MISS_Y      (450)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_tick  (frame_tick),
    .start_btn   (start_btn),
    .paddle_hit  (paddle_hit),
    .ball_y      (ball_y),
    .ball_move_en(ball_move_en),
    .ball_serve  (ball_serve),
    .score_bcd   (score_bcd),
    .lives       (lives),
    .game_over   (game_over),
    .state_dbg   (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
  endtask

  task automatic scoringFrame();
    paddle_hit = 1'b1;
    step();
    paddle_hit = 1'b0;
    tick();
  endtask

  task automatic serveToPlay();
    for (int i = 1; i <= 59; i++) begin
      tick();
      chk("serve_hold_move", ball_move_en, 1'b0);
    end
    tick();
    chk("serve_done_state", state_dbg, 3'd2);
    chk("serve_done_move", ball_move_en, 1'b1);
  endtask

  task automatic missNow(input logic [1:0] livesAfter);
    ball_y = 9'd450;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    ball_y = 9'd100;
    chk("miss_state", state_dbg, 3'd3);
    chk("miss_move", ball_move_en, 1'b0);
    step();
    chk("miss_lives", lives, livesAfter);
  endtask

  initial begin
    rst = 1'b1;
    start_btn = 1'b1;
    frame_tick = 1'b0;
    paddle_hit = 1'b0;
    ball_y = 9'd100;
    step();
    step();
    chk("rst_state", state_dbg, 3'd0);
    chk("rst_score", score_bcd, 8'h00);
    chk("rst_lives", lives, 2'd3);
    chk("rst_move", ball_move_en, 1'b0);
    chk("rst_serve", ball_serve, 1'b0);
    chk("rst_go", game_over, 1'b0);

    // Button held through reset must not start a game.
    rst = 1'b0;
    step();
    step();
    step();
    chk("held_no_start", state_dbg, 3'd0);
    chk("held_no_serve", ball_serve, 1'b0);

    start_btn = 1'b0;
    step();
    start_btn = 1'b1;
    step();
    chk("start_state", state_dbg, 3'd1);
    chk("start_serve", ball_serve, 1'b1);
    chk("start_lives", lives, 2'd3);
    chk("start_score", score_bcd, 8'h00);
    start_btn = 1'b0;
    step();
    chk("serve_one_cycle", ball_serve, 1'b0);

    // Hits during SERVE are ignored.
    paddle_hit = 1'b1;
    step();
    paddle_hit = 1'b0;
    chk("serve_hit_ignored", score_bcd, 8'h00);

    serveToPlay();

    // Three hits in one frame score once.
    for (int i = 0; i < 3; i++) begin
      paddle_hit = 1'b1;
      step();
      paddle_hit = 1'b0;
      step();
    end
    tick();
    chk("multi_hit_one", score_bcd, 8'h01);
    for (int i = 2; i <= 9; i++) scoringFrame();
    chk("score_09", score_bcd, 8'h09);
    scoringFrame();
    chk("score_10", score_bcd, 8'h10);

    // Start pressed in PLAY is ignored.
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
    step();
    chk("play_start_ignored", state_dbg, 3'd2);

    for (int i = 11; i <= 98; i++) scoringFrame();
    chk("score_98", score_bcd, 8'h98);
    scoringFrame();
    chk("sat_99_a", score_bcd, 8'h99);
    scoringFrame();
    chk("sat_99_b", score_bcd, 8'h99);
    scoringFrame();
    chk("sat_99_c", score_bcd, 8'h99);

    // Boundary row 449 is not a miss.
    ball_y = 9'd449;
    tick();
    chk("y449_play", state_dbg, 3'd2);
    chk("y449_lives", lives, 2'd3);

    missNow(2'd2);
    chk("miss1_state", state_dbg, 3'd1);
    chk("miss1_serve", ball_serve, 1'b1);
    step();
    chk("miss1_serve_off", ball_serve, 1'b0);
    serveToPlay();

    missNow(2'd1);
    chk("miss2_state", state_dbg, 3'd1);
    serveToPlay();

    // Hold start through the final miss; game over must ignore it until released.
    start_btn = 1'b1;
    step();
    missNow(2'd0);
    chk("go_state", state_dbg, 3'd4);
    chk("go_flag", game_over, 1'b1);
    chk("go_serve", ball_serve, 1'b0);
    chk("go_move", ball_move_en, 1'b0);
    paddle_hit = 1'b1;
    step();
    paddle_hit = 1'b0;
    step();
    chk("go_held_state", state_dbg, 3'd4);
    chk("go_score_hold", score_bcd, 8'h99);
    chk("go_lives_hold", lives, 2'd0);

    start_btn = 1'b0;
    step();
    start_btn = 1'b1;
    step();
    chk("restart_state", state_dbg, 3'd1);
    chk("restart_score", score_bcd, 8'h00);
    chk("restart_lives", lives, 2'd3);
    chk("restart_go", game_over, 1'b0);
    chk("restart_serve", ball_serve, 1'b1);
    start_btn = 1'b0;
    step();
    serveToPlay();

    // Hit on the same cycle as a miss-qualifying tick: scored, then MISS.
    ball_y = 9'd460;
    paddle_hit = 1'b1;
    frame_tick = 1'b1;
    step();
    paddle_hit = 1'b0;
    frame_tick = 1'b0;
    ball_y = 9'd100;
    chk("simul_score", score_bcd, 8'h01);
    chk("simul_state", state_dbg, 3'd3);
    step();
    chk("simul_lives", lives, 2'd2);
    chk("simul_serve_state", state_dbg, 3'd1);
    serveToPlay();

    scoringFrame();
    chk("pre_rst_score", score_bcd, 8'h02);
    rst = 1'b1;
    step();
    chk("midrst_state", state_dbg, 3'd0);
    chk("midrst_score", score_bcd, 8'h00);
    chk("midrst_lives", lives, 2'd3);
    chk("midrst_move", ball_move_en, 1'b0);
    chk("midrst_serve", ball_serve, 1'b0);
    chk("midrst_go", game_over, 1'b0);
    rst = 1'b0;
    step();
    chk("post_rst_idle", state_dbg, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
